// File: rtl/exec_arith_branch_unit_pkg.sv
// Shared widths, opcode encodings and branch condition codes for the
// execute-stage arithmetic/branch slice.
package exec_arith_branch_unit_pkg;

  localparam int unsigned W_OPR = 32;
  localparam int unsigned W_IMM = 16;
  localparam int unsigned W_OPC = 7;
  localparam int unsigned ADDR  = 32;

  // ALU and jump codes live in opecode[4:0]; CMP is matched on the full opcode.
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_ABS = 5'b00101;
  localparam logic [4:0] OP_J   = 5'b11100;
  localparam logic [4:0] OP_JA  = 5'b11101;
  localparam logic [6:0] OP_CMP = 7'b000_0100;

  typedef enum logic [1:0] {
    COND_AL = 2'b00,
    COND_EQ = 2'b01,
    COND_NE = 2'b10,
    COND_LT = 2'b11
  } cond_e;

endpackage

// File: rtl/exec_absx.sv
// Two's-complement absolute value; the most-negative value negates to itself.
module exec_absx #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] result
);

  always_comb begin
    result = a[W-1] ? ('0 - a) : a;
  end

endmodule

// File: rtl/exec_addx.sv
// Adder/subtractor leaf: result = a + b, or a - b when sub is set.
module exec_addx #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result
);

  always_comb begin
    result = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/exec_branch.sv
// Branch resolution: evaluates the condition field against registered flags
// and produces the take strobe plus relative/absolute target.
module exec_branch
  import exec_arith_branch_unit_pkg::*;
#(
  parameter int unsigned W_OPR = 32,
  parameter int unsigned W_OPC = 7,
  parameter int unsigned ADDR  = 32
) (
  input  logic [W_OPR-1:0] opr0,
  input  logic [W_OPR-1:0] src,
  input  logic             v,
  input  logic [ADDR-1:0]  pc,
  input  logic [W_OPC-1:0] opcode,
  input  logic             c,
  input  logic             z,
  input  logic             s,
  input  logic             o,
  output logic             branch,
  output logic [ADDR-1:0]  addr
);

  logic  is_j;
  logic  is_ja;
  logic  cond_true;
  cond_e cond;

  // opr0 and carry are part of the port set but play no role in branching.
  logic unused_inputs;
  assign unused_inputs = ^{opr0, c};

  assign is_j  = (opcode[4:0] == OP_J);
  assign is_ja = (opcode[4:0] == OP_JA);
  assign cond  = cond_e'(opcode[6:5]);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_LT: cond_true = s ^ o;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    addr = '0;
    if (is_j)
      addr = pc + src[ADDR-1:0];
    else if (is_ja)
      addr = src[ADDR-1:0];
  end

  assign branch = v & (is_j | is_ja) & cond_true;

endmodule

// File: rtl/exec_arith_branch_unit.sv
// Execute-stage slice: add/sub/abs result, CMP-driven condition flags and
// branch redirect. Only the flags are clocked.
module exec_arith_branch_unit #(
  parameter int unsigned W_OPR = exec_arith_branch_unit_pkg::W_OPR,
  parameter int unsigned W_IMM = exec_arith_branch_unit_pkg::W_IMM,
  parameter int unsigned W_OPC = exec_arith_branch_unit_pkg::W_OPC,
  parameter int unsigned ADDR  = exec_arith_branch_unit_pkg::ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  input  logic             stall_i,
  input  logic [W_OPC-1:0] opecode_i,
  input  logic [W_OPR-1:0] opr0_i,
  input  logic [W_OPR-1:0] opr1_i,
  input  logic             immf_i,
  input  logic             immsign_i,
  input  logic [W_IMM-1:0] imm_i,
  input  logic [ADDR-1:0]  pc_i,
  output logic [W_OPR-1:0] result_o,
  output logic [3:0]       flags_o,
  output logic             branch_o,
  output logic [ADDR-1:0]  branch_addr_o
);

  import exec_arith_branch_unit_pkg::*;

  logic [W_OPR-1:0] src;
  logic [W_OPR-1:0] add_res;
  logic [W_OPR-1:0] abs_res;
  logic [W_OPR:0]   cmp_diff;
  logic [3:0]       cmp_flags;
  logic [3:0]       flags;
  logic             cmp_en;

  assign src = immf_i ? {{(W_OPR-W_IMM){immsign_i & imm_i[W_IMM-1]}}, imm_i} : opr1_i;

  // Extra top bit of the widened difference is the unsigned borrow.
  assign cmp_diff  = {1'b0, opr0_i} - {1'b0, src};
  assign cmp_flags = {cmp_diff[W_OPR],
                      (cmp_diff[W_OPR-1:0] == '0),
                      cmp_diff[W_OPR-1],
                      (opr0_i[W_OPR-1] != src[W_OPR-1]) &&
                      (cmp_diff[W_OPR-1] != opr0_i[W_OPR-1])};

  assign cmp_en = v_i & ~stall_i & (opecode_i == OP_CMP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      flags <= '0;
    else if (cmp_en)
      flags <= cmp_flags;
  end

  assign flags_o = flags;

  exec_addx #(.W(W_OPR)) u_addx (
    .a      (opr0_i),
    .b      (src),
    .sub    (opecode_i[0]),
    .result (add_res)
  );

  exec_absx #(.W(W_OPR)) u_absx (
    .a      (src),
    .result (abs_res)
  );

  always_comb begin
    result_o = '0;
    case (opecode_i[4:0])
      OP_ADD, OP_SUB: result_o = add_res;
      OP_ABS:         result_o = abs_res;
      default:        result_o = '0;
    endcase
  end

  exec_branch #(.W_OPR(W_OPR), .W_OPC(W_OPC), .ADDR(ADDR)) u_branch (
    .opr0   (opr0_i),
    .src    (src),
    .v      (v_i),
    .pc     (pc_i),
    .opcode (opecode_i),
    .c      (flags[3]),
    .z      (flags[2]),
    .s      (flags[1]),
    .o      (flags[0]),
    .branch (branch_o),
    .addr   (branch_addr_o)
  );

endmodule

// File: tb/tb_exec_arith_branch_unit.sv
// Directed-vector bench: the driver pushes hand-computed expectations into a
// queue and a negedge monitor pops and compares them against the DUT outputs.
module tb_exec_arith_branch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        v_i = 1'b0;
  logic        stall_i = 1'b0;
  logic [6:0]  opecode_i = '0;
  logic [31:0] opr0_i = '0;
  logic [31:0] opr1_i = '0;
  logic        immf_i = 1'b0;
  logic        immsign_i = 1'b0;
  logic [15:0] imm_i = '0;
  logic [31:0] pc_i = '0;
  logic [31:0] result_o;
  logic [3:0]  flags_o;
  logic        branch_o;
  logic [31:0] branch_addr_o;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        br;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  exec_arith_branch_unit #(.W_OPR(32), .W_IMM(16), .W_OPC(7), .ADDR(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .v_i           (v_i),
    .stall_i       (stall_i),
    .opecode_i     (opecode_i),
    .opr0_i        (opr0_i),
    .opr1_i        (opr1_i),
    .immf_i        (immf_i),
    .immsign_i     (immsign_i),
    .imm_i         (imm_i),
    .pc_i          (pc_i),
    .result_o      (result_o),
    .flags_o       (flags_o),
    .branch_o      (branch_o),
    .branch_addr_o (branch_addr_o)
  );

  always #5 clk = ~clk;

  // Expected flags are those visible during this cycle, i.e. before this
  // cycle's CMP (if any) lands at the next rising edge.
  task automatic drive(input string name, input logic rst_n, input logic v,
                       input logic stall, input logic [6:0] opc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic immf, input logic immsign,
                       input logic [15:0] imm, input logic [31:0] pc,
                       input logic [31:0] e_res, input logic [3:0] e_flags,
                       input logic e_br, input logic [31:0] e_addr);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_n; v_i = v; stall_i = stall; opecode_i = opc;
    opr0_i = a; opr1_i = b; immf_i = immf; immsign_i = immsign;
    imm_i = imm; pc_i = pc;
    e.name = name; e.res = e_res; e.flags = e_flags; e.br = e_br; e.addr = e_addr;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, "result", result_o, e.res);
      check(e.name, "flags", {28'd0, flags_o}, {28'd0, e.flags});
      check(e.name, "branch", {31'd0, branch_o}, {31'd0, e.br});
      check(e.name, "addr", branch_addr_o, e.addr);
    end
  end

  initial begin
    //     name        rst v  st opc         opr0          opr1          if is imm      pc            res           flg    br addr
    drive("reset",     0, 0, 0, 7'b0000000, 32'h0,        32'h0,        0, 0, 16'h0,   32'h0,        32'h0,        4'h0, 0, 32'h0);
    drive("add_ovf",   1, 1, 0, 7'b0000000, 32'h7FFFFFFF, 32'h1,        0, 0, 16'h0,   32'h0,        32'h80000000, 4'h0, 0, 32'h0);
    drive("sub_imm",   1, 1, 0, 7'b0000001, 32'h5,        32'h0,        1, 1, 16'hFFFF,32'h0,        32'h6,        4'h0, 0, 32'h0);
    drive("abs_neg",   1, 1, 0, 7'b0000101, 32'h0,        32'hFFFFFFFB, 0, 0, 16'h0,   32'h0,        32'h5,        4'h0, 0, 32'h0);
    drive("abs_min",   1, 1, 0, 7'b0000101, 32'h0,        32'h80000000, 0, 0, 16'h0,   32'h0,        32'h80000000, 4'h0, 0, 32'h0);
    drive("abs_immz",  1, 1, 0, 7'b0000101, 32'h0,        32'h0,        1, 0, 16'h8000,32'h0,        32'h8000,     4'h0, 0, 32'h0);
    drive("add_hibit", 1, 1, 0, 7'b1100000, 32'd10,       32'd20,       0, 0, 16'h0,   32'h0,        32'd30,       4'h0, 0, 32'h0);
    drive("unk_op",    1, 1, 0, 7'b0000010, 32'd9,        32'd3,        0, 0, 16'h0,   32'h0,        32'h0,        4'h0, 0, 32'h0);
    drive("cmp_3_5",   1, 1, 0, 7'b0000100, 32'd3,        32'd5,        0, 0, 16'h0,   32'h0,        32'h0,        4'h0, 0, 32'h0);
    drive("cmp_stall", 1, 1, 1, 7'b0000100, 32'd7,        32'd7,        0, 0, 16'h0,   32'h0,        32'h0,        4'hA, 0, 32'h0);
    drive("cmp_nov",   1, 0, 0, 7'b0000100, 32'd7,        32'd7,        0, 0, 16'h0,   32'h0,        32'h0,        4'hA, 0, 32'h0);
    drive("cmp_7_7",   1, 1, 0, 7'b0000100, 32'd7,        32'd7,        0, 0, 16'h0,   32'h0,        32'h0,        4'hA, 0, 32'h0);
    drive("j_eq",      1, 1, 0, 7'b0111100, 32'hDEAD,     32'h0,        1, 0, 16'h0010,32'h100,      32'h0,        4'h4, 1, 32'h110);
    drive("j_ne",      1, 1, 0, 7'b1011100, 32'h0,        32'h0,        1, 0, 16'h0010,32'h100,      32'h0,        4'h4, 0, 32'h110);
    drive("ja_v1",     1, 1, 0, 7'b0011101, 32'h0,        32'h2000,     0, 0, 16'h0,   32'h100,      32'h0,        4'h4, 1, 32'h2000);
    drive("ja_v0",     1, 0, 0, 7'b0011101, 32'h0,        32'h2000,     0, 0, 16'h0,   32'h100,      32'h0,        4'h4, 0, 32'h2000);
    drive("cmp_ovf",   1, 1, 0, 7'b0000100, 32'h80000000, 32'h1,        0, 0, 16'h0,   32'h0,        32'h0,        4'h4, 0, 32'h0);
    drive("j_lt_wrap", 1, 1, 0, 7'b1111100, 32'h0,        32'h0,        1, 0, 16'h0020,32'hFFFFFFF0, 32'h0,        4'h1, 1, 32'h10);
    drive("cmp_imm",   1, 1, 0, 7'b0000100, 32'h1,        32'h0,        1, 1, 16'hFFFF,32'h0,        32'h0,        4'h1, 0, 32'h0);
    drive("j_lt_no",   1, 1, 0, 7'b1111100, 32'h0,        32'h0,        1, 1, 16'hFFF0,32'h40,       32'h0,        4'h8, 0, 32'h30);
    drive("cmp_again", 1, 1, 0, 7'b0000100, 32'd3,        32'd5,        0, 0, 16'h0,   32'h0,        32'h0,        4'h8, 0, 32'h0);
    drive("add_pre",   1, 0, 0, 7'b0000000, 32'd1,        32'd1,        0, 0, 16'h0,   32'h0,        32'd2,        4'hA, 0, 32'h0);
    drive("async_rst", 0, 0, 0, 7'b0000000, 32'h0,        32'h0,        0, 0, 16'h0,   32'h0,        32'h0,        4'h0, 0, 32'h0);
    drive("post_rst",  1, 0, 0, 7'b0000000, 32'd4,        32'd4,        0, 0, 16'h0,   32'h0,        32'd8,        4'h0, 0, 32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
